// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker
// On-chip self-test engine for a 2-input, 1-output combinational gate.
// It drives the gate's a/b inputs through all four combinations, waits
// SETTLE_CYCLES for the gate to settle, samples c and compares it against the
// EXPECT truth table. It reports pass, a per-vector mismatch mask and a
// mismatch count.
//
// Control signalling: start and abort are single-cycle-sampled requests with
// no ready/acknowledge. start is accepted only in IDLE; if both are high in
// IDLE, start wins. abort is honoured only in DRIVE/SAMPLE. It is ignored in
// IDLE and in DONE. busy reports that a request is in progress. done pulses
// for one cycle when a sweep completes. pass/fail_mask/err_count stay valid
// from done until the next accepted start.
//
// The FSM state is held in the named signal 'state' so that checkers can be
// bound to it directly.
module gate_sweep_checker #(
    parameter logic [3:0]  EXPECT        = 4'b1000,  // bit i = expected c for {a,b}=i
    parameter int unsigned SETTLE_CYCLES = 2         // legal range 1..255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       a,
    output logic       b,
    input  logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [2:0] err_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Last value of the settle counter before moving on to SAMPLE.
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [1:0] idx;
    logic [1:0] idx_next;
    logic [7:0] settle;
    logic       miss;

    // Compare the gate output against the truth-table entry of the current vector.
    assign miss     = (c != EXPECT[idx]);
    assign idx_next = idx + 2'd1;

    // Sweep sequencer. All outputs are registered here so that a/b never glitch
    // into the gate under test.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= 2'd0;
            settle    <= 8'd0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= 4'd0;
            err_count <= 3'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // abort is meaningless here, so start always wins.
                    if (start) begin
                        state     <= DRIVE;
                        idx       <= 2'd0;
                        settle    <= 8'd0;
                        a         <= 1'b0;
                        b         <= 1'b0;
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                        fail_mask <= 4'd0;
                        err_count <= 3'd0;
                    end
                end

                DRIVE: begin
                    if (abort) begin
                        // Partial fail_mask/err_count are kept for diagnosis.
                        state <= IDLE;
                        idx   <= 2'd0;
                        a     <= 1'b0;
                        b     <= 1'b0;
                        busy  <= 1'b0;
                        pass  <= 1'b0;
                    end else begin
                        settle <= settle + 8'd1;
                        if (settle == SETTLE_LAST) begin
                            state <= SAMPLE;
                        end
                    end
                end

                SAMPLE: begin
                    if (abort) begin
                        // An aborted vector's sample is discarded.
                        state <= IDLE;
                        idx   <= 2'd0;
                        a     <= 1'b0;
                        b     <= 1'b0;
                        busy  <= 1'b0;
                        pass  <= 1'b0;
                    end else begin
                        if (miss) begin
                            fail_mask[idx] <= 1'b1;
                            err_count      <= err_count + 3'd1;
                        end
                        if (idx == 2'd3) begin
                            state <= DONE;
                            done  <= 1'b1;
                            pass  <= (err_count == 3'd0) && !miss;
                        end else begin
                            state  <= DRIVE;
                            idx    <= idx_next;
                            a      <= idx_next[1];
                            b      <= idx_next[0];
                            settle <= 8'd0;
                        end
                    end
                end

                DONE: begin
                    // done has pulsed for this single cycle; abort is ignored.
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker. Two instances share the clock and reset:
// dut0 uses the default AND table with SETTLE_CYCLES=2, and dut1 uses
// EXPECT=4'b0110 with SETTLE_CYCLES=1. The gate feeding c is chosen per
// sweep. Expected results come from a small truth-table model. They are
// queued when a sweep is started and popped when done pulses.
module tb_gate_sweep_checker;

    logic clk = 1'b0;
    logic rst_n;

    // Clock generation.
    always #5 clk = ~clk;

    logic start0, abort0, a0, b0, c0, busy0, done0, pass0;
    logic [3:0] fm0;
    logic [2:0] ec0;
    logic start1, abort1, a1, b1, c1, busy1, done1, pass1;
    logic [3:0] fm1;
    logic [2:0] ec1;

    // gate codes: 0 AND, 1 tied 0, 2 tied 1, 3 XOR
    int gate0;
    int gate1;
    bit sel;

    logic [1:0] ab_m;
    logic       busy_m, done_m;
    logic [7:0] res_m;

    logic [7:0] exp_q[$];
    int n_asserts;
    int n_fail;

    gate_sweep_checker dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .a(a0), .b(b0), .c(c0), .busy(busy0), .done(done0), .pass(pass0),
        .fail_mask(fm0), .err_count(ec0)
    );

    gate_sweep_checker #(.EXPECT(4'b0110), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_mask(fm1), .err_count(ec1)
    );

    // Gates under test.
    always_comb begin
        c0 = 1'b0;
        case (gate0)
            0:       c0 = a0 & b0;
            1:       c0 = 1'b0;
            2:       c0 = 1'b1;
            default: c0 = a0 ^ b0;
        endcase
        c1 = (gate1 == 3) ? (a1 ^ b1) : (a1 & b1);
    end

    // Monitor view of the selected instance.
    always_comb begin
        ab_m   = sel ? {a1, b1} : {a0, b0};
        busy_m = sel ? busy1 : busy0;
        done_m = sel ? done1 : done0;
        res_m  = sel ? {pass1, fm1, ec1} : {pass0, fm0, ec0};
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {pass, fail_mask, err_count} for a gate against a truth table.
    function automatic logic [7:0] model(input logic [3:0] expv, input int gate);
        logic [3:0] m;
        logic [2:0] n;
        logic       cv;
        logic [1:0] v;
        m = 4'd0;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            v = 2'(i);
            case (gate)
                0:       cv = v[1] & v[0];
                1:       cv = 1'b0;
                2:       cv = 1'b1;
                default: cv = v[1] ^ v[0];
            endcase
            if (cv != expv[i]) begin
                m[i] = 1'b1;
                n    = n + 3'd1;
            end
        end
        return {(n == 3'd0), m, n};
    endfunction

    task automatic set_start(input logic v);
        if (sel) start1 = v; else start0 = v;
    endtask

    task automatic set_abort(input logic v);
        if (sel) abort1 = v; else abort0 = v;
    endtask

    // Runs one sweep on the selected instance. p is cycles per vector.
    // restart_at/abort_at are the edges (counting the start edge as 0) at which
    // start/abort are sampled high; 0 means never.
    task automatic sweep(input string tag, input int p, input logic [7:0] expected,
                         input int restart_at, input int abort_at, input bit abort_with_start);
        int e;
        bit seen;
        logic [7:0] exp_r;
        @(negedge clk);
        exp_q.push_back(expected);
        set_start(1'b1);
        set_abort(abort_with_start);
        @(posedge clk);
        #1;
        set_start(1'b0);
        set_abort(1'b0);
        check({tag, "/busy_after_start"}, 8'(busy_m), 8'd1);
        e = 0;
        seen = 0;
        exp_r = 8'd0;
        while (!seen && e < 60) begin
            if (e + 1 == restart_at) set_start(1'b1);
            if (e + 1 == abort_at) set_abort(1'b1);
            @(posedge clk);
            #1;
            e++;
            set_start(1'b0);
            set_abort(1'b0);
            if (e < 4 * p && (e % p) == 1)
                check({tag, "/ab"}, 8'(ab_m), 8'(e / p));
            if (done_m) begin
                seen = 1;
                check({tag, "/done_edge"}, 8'(e), 8'(4 * p));
                exp_r = exp_q.pop_front();
                check({tag, "/result"}, res_m, exp_r);
            end
        end
        if (!seen) begin
            check({tag, "/done_timeout"}, 8'd0, 8'd1);
            if (exp_q.size() > 0) exp_r = exp_q.pop_front();
        end
        if (abort_at == e + 1) set_abort(1'b1);
        @(posedge clk);
        #1;
        set_abort(1'b0);
        check({tag, "/idle_after_done"}, {6'd0, busy_m, done_m}, 8'd0);
        check({tag, "/result_held"}, res_m, exp_r);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int done_seen;
        n_asserts = 0;
        n_fail    = 0;
        sel = 0;
        gate0 = 0;
        gate1 = 3;
        start0 = 0; abort0 = 0; start1 = 0; abort1 = 0;

        // Reset state.
        rst_n = 1'b0;
        #12;
        check("reset/dut0", {a0, b0, busy0, done0, pass0, fm0[2:0]}, 8'd0);
        check("reset/dut0_hi", {fm0[3], ec0, 4'd0}, 8'd0);
        check("reset/dut1", {a1, b1, busy1, done1, pass1, fm1[2:0]}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // AND gate, defaults.
        sweep("and", 3, model(4'b1000, 0), 0, 0, 0);
        // Back-to-back: the next start arrives in the cycle after done.
        gate0 = 1;
        sweep("tie0", 3, model(4'b1000, 1), 0, 0, 0);
        gate0 = 2;
        sweep("tie1", 3, model(4'b1000, 2), 0, 0, 0);

        // Re-pulsed start while busy, start+abort together in IDLE, abort in DONE.
        gate0 = 0;
        sweep("restart", 3, model(4'b1000, 0), 5, 0, 0);
        sweep("start_abort", 3, model(4'b1000, 0), 0, 0, 1);
        sweep("abort_in_done", 3, model(4'b1000, 0), 0, 13, 0);

        // Second table with shorter settle time.
        sel = 1;
        gate1 = 3;
        sweep("xor_0110", 2, model(4'b0110, 3), 0, 0, 0);
        gate1 = 0;
        sweep("and_0110", 2, model(4'b0110, 0), 0, 0, 0);
        sel = 0;

        // Abort mid-sweep: vector 0 mismatches, vector 1's sample is discarded.
        gate0 = 2;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        abort0 = 1'b1;
        @(posedge clk);
        #1;
        abort0 = 1'b0;
        check("abort/busy_ab_pass", {5'd0, busy0, a0, b0}, 8'd0);
        check("abort/partial", {pass0, fm0, ec0}, {1'b0, 4'b0001, 3'd1});
        done_seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done0) done_seen++;
        end
        check("abort/no_done", 8'(done_seen), 8'd0);
        check("abort/stays_idle", 8'(busy0), 8'd0);

        // Asynchronous reset in DRIVE of vector 2.
        gate0 = 0;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("pre_reset/ab", {6'd0, a0, b0}, 8'd2);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset/outs", {a0, b0, busy0, done0, pass0, fm0[2:0]}, 8'd0);
        check("async_reset/outs_hi", {fm0[3], ec0, 4'd0}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep("after_reset", 3, model(4'b1000, 0), 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
